// File: rtl/esm_issue_scheduler_if.sv
// Interface bundling the allocation, dependency and issue handshake signals
// of the ESM shuffle-buffer issue scheduler.
//   master : upstream/issue-stage side (drives requests, flush, dep_ready, issue_ready)
//   slave  : the scheduler itself
interface esm_issue_scheduler_if #(
    parameter int BS = 16
);
    localparam int IDX_W = $clog2(BS);

    logic             flush;
    logic             alloc_req;
    logic             alloc_gnt;
    logic [IDX_W-1:0] alloc_idx;
    logic [BS-1:0]    dep_ready;
    logic             issue_valid;
    logic             issue_ready;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W:0]   occupancy;
    logic             full;
    logic             empty;

    modport master (
        output flush, alloc_req, dep_ready, issue_ready,
        input  alloc_gnt, alloc_idx, issue_valid, issue_idx, occupancy, full, empty
    );

    modport slave (
        input  flush, alloc_req, dep_ready, issue_ready,
        output alloc_gnt, alloc_idx, issue_valid, issue_idx, occupancy, full, empty
    );
endinterface

// File: rtl/esm_issue_scheduler.sv
// Slot controller and issue scheduler for the ESM shuffle buffer.
// Allocates the lowest free slot per incoming instruction, tracks occupancy,
// and offers one dependency-resolved slot at a time over a valid/ready
// handshake, picking from a rotating start point.
// Build option: define ESM_SCHED_RR_EN for a deterministic round-robin start
// (last issued index + 1); otherwise the start comes from a free-running
// 16-bit Galois LFSR (mask 16'hB400).
// BS must match the BS parameter of the connected interface.
module esm_issue_scheduler #(
    parameter int          BS        = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                  clk,
    input logic                  rst_n,
    esm_issue_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(BS);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state;
    logic [BS-1:0]    occupied;
    logic [IDX_W:0]   occ_cnt;
    logic             issue_valid_q;
    logic [IDX_W-1:0] issue_idx_q;

    logic             full;
    logic             alloc_gnt;
    logic [IDX_W-1:0] alloc_idx;
    logic             hs;
    logic [BS-1:0]    offer_mask;
    logic [BS-1:0]    cand;
    logic             cand_any;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pick;

    assign full      = (occ_cnt == (IDX_W+1)'(BS));
    assign alloc_gnt = bus.alloc_req & ~full & ~bus.flush;
    assign hs        = issue_valid_q & bus.issue_ready;

    // The slot on offer is excluded so a handshake re-latch never re-picks it;
    // slots granted this cycle are not yet in occupied, so they wait a cycle.
    assign offer_mask = issue_valid_q ? (BS'(1) << issue_idx_q) : '0;
    assign cand       = occupied & bus.dep_ready & ~offer_mask;
    assign cand_any   = |cand;

`ifdef ESM_SCHED_RR_EN
    logic [IDX_W-1:0] rr_next;

    // Round-robin pointer: one past the most recently accepted slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rr_next <= '0;
        else if (bus.flush) rr_next <= '0;
        else if (hs)        rr_next <= issue_idx_q + IDX_W'(1);
    end

    // A re-latch in the handshake cycle already starts after the slot being issued.
    assign start = hs ? issue_idx_q + IDX_W'(1) : rr_next;
`else
    logic [15:0] lfsr;

    // Free-running Galois LFSR; deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign start = lfsr[IDX_W-1:0];
`endif

    // Lowest-index free slot: scan downwards so the smallest index is assigned last.
    always_comb begin
        // NOTE: default every combinational output before the loop so no latch is inferred.
        alloc_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!occupied[i]) alloc_idx = IDX_W'(i);
        end
    end

    // First candidate at or above start, wrapping modulo BS (BS is a power of 2).
    always_comb begin
        pick = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (cand[start + IDX_W'(i)]) pick = start + IDX_W'(i);
        end
    end

    // Occupancy bookkeeping and the IDLE/OFFER issue FSM; flush overrides alloc and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state         <= IDLE;
            occupied      <= '0;
            occ_cnt       <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else if (bus.flush) begin
            state         <= IDLE;
            occupied      <= '0;
            occ_cnt       <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            occupied <= (occupied | (alloc_gnt ? (BS'(1) << alloc_idx) : '0))
                        & ~(hs ? offer_mask : '0);
            occ_cnt  <= occ_cnt + (IDX_W+1)'(alloc_gnt) - (IDX_W+1)'(hs);
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        issue_idx_q   <= pick;
                        issue_valid_q <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (hs) begin
                        if (cand_any) begin
                            issue_idx_q <= pick;
                        end else begin
                            issue_valid_q <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: begin
                    issue_valid_q <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.alloc_gnt   = alloc_gnt;
    assign bus.alloc_idx   = alloc_idx;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx   = issue_idx_q;
    assign bus.occupancy   = occ_cnt;
    assign bus.full        = full;
    assign bus.empty       = (occ_cnt == '0);
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Self-checking bench for esm_issue_scheduler. Build with ESM_SCHED_RR_EN to
// exercise the round-robin start; the default build checks the LFSR start
// against a reference sequence computed here.
module tb_esm_issue_scheduler;
    localparam int          BS    = 16;
    localparam int          IDX_W = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    esm_issue_scheduler_if #(.BS(BS)) bus();

    esm_issue_scheduler #(.BS(BS), .LFSR_SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifndef ESM_SCHED_RR_EN
    // Reference LFSR sequence: value seen by the scheduler during the current cycle.
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end
`endif

    // First set member at or after position s, wrapping; -1 if the set is empty.
    function automatic int first_from(input logic [BS-1:0] set, input int s);
        for (int k = 0; k < BS; k++) begin
            if (set[(s + k) % BS]) return (s + k) % BS;
        end
        return -1;
    endfunction

    task automatic do_reset();
        bus.flush       = 1'b0;
        bus.alloc_req   = 1'b0;
        bus.dep_ready   = '0;
        bus.issue_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic alloc_n(input int n);
        bus.alloc_req = 1'b1;
        repeat (n) @(negedge clk);
        bus.alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", bus.issue_valid); end
        n_checks++; if (bus.issue_idx !== 4'd0) begin n_fail++; $display("FAIL rst_idx: got %0d expected 0", bus.issue_idx); end
        n_checks++; if (bus.occupancy !== 5'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", bus.occupancy); end
        n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got empty=%0b full=%0b expected 1/0", bus.empty, bus.full); end
        // Bring one slot to OFFER, then drop reset between clock edges.
        bus.dep_ready = '1;
        alloc_n(1);
        @(negedge clk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd0) begin n_fail++; $display("FAIL pre_rst_offer: got valid=%0b idx=%0d expected 1/0", bus.issue_valid, bus.issue_idx); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %0b expected 0", bus.issue_valid); end
        n_checks++; if (bus.occupancy !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_occ: got occ=%0d empty=%0b expected 0/1", bus.occupancy, bus.empty); end
        bus.dep_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i <= BS; i++) begin
            bus.alloc_req = 1'b1;
            #1;
            n_checks++; if (bus.occupancy !== 5'(i)) begin n_fail++; $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, bus.occupancy, i); end
            n_checks++; if (bus.alloc_gnt !== (i < BS)) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %0b expected %0b", i, bus.alloc_gnt, i < BS); end
            if (i < BS) begin
                n_checks++; if (bus.alloc_idx !== 4'(i)) begin n_fail++; $display("FAIL fill_idx[%0d]: got %0d expected %0d", i, bus.alloc_idx, i); end
            end else begin
                n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b expected 1", bus.full); end
            end
            @(negedge clk);
        end
        bus.alloc_req = 1'b0;
        n_checks++; if (bus.occupancy !== 5'd16 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL fill_end: got occ=%0d valid=%0b expected 16/0", bus.occupancy, bus.issue_valid); end
    endtask

    // Runs straight after test_fill: buffer full, nothing offered.
    task automatic test_concurrent();
        bus.dep_ready = 16'h0080;
        @(negedge clk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd7) begin n_fail++; $display("FAIL conc_offer: got valid=%0b idx=%0d expected 1/7", bus.issue_valid, bus.issue_idx); end
        bus.dep_ready   = '0;
        bus.issue_ready = 1'b1;
        bus.alloc_req   = 1'b1;
        #1;
        n_checks++; if (bus.alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL conc_gnt_full: got %0b expected 0", bus.alloc_gnt); end
        n_checks++; if (bus.occupancy !== 5'd16) begin n_fail++; $display("FAIL conc_occ16: got %0d expected 16", bus.occupancy); end
        @(negedge clk);
        bus.issue_ready = 1'b0;
        #1;
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd15) begin n_fail++; $display("FAIL conc_after_hs: got valid=%0b occ=%0d expected 0/15", bus.issue_valid, bus.occupancy); end
        n_checks++; if (bus.alloc_gnt !== 1'b1 || bus.alloc_idx !== 4'd7) begin n_fail++; $display("FAIL conc_realloc: got gnt=%0b idx=%0d expected 1/7", bus.alloc_gnt, bus.alloc_idx); end
        @(negedge clk);
        bus.alloc_req = 1'b0;
        n_checks++; if (bus.occupancy !== 5'd16 || bus.full !== 1'b1) begin n_fail++; $display("FAIL conc_refull: got occ=%0d full=%0b expected 16/1", bus.occupancy, bus.full); end
    endtask

    task automatic test_stall();
        do_reset();
        alloc_n(6);
        bus.dep_ready = 16'h0020;
        @(negedge clk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd5) begin n_fail++; $display("FAIL stall_offer: got valid=%0b idx=%0d expected 1/5", bus.issue_valid, bus.issue_idx); end
        bus.dep_ready = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'd5) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%0b idx=%0d expected 1/5", c, bus.issue_valid, bus.issue_idx); end
        end
        bus.issue_ready = 1'b1;
        @(negedge clk);
        bus.issue_ready = 1'b0;
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd5) begin n_fail++; $display("FAIL stall_accept: got valid=%0b occ=%0d expected 0/5", bus.issue_valid, bus.occupancy); end
    endtask

`ifdef ESM_SCHED_RR_EN
    task automatic test_rr();
        do_reset();
        alloc_n(4);
        bus.dep_ready   = 16'h000F;
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 4'(k)) begin n_fail++; $display("FAIL rr_seq[%0d]: got valid=%0b idx=%0d expected 1/%0d", k, bus.issue_valid, bus.issue_idx, k); end
        end
        @(negedge clk);
        bus.issue_ready = 1'b0;
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rr_drained: got valid=%0b empty=%0b expected 0/1", bus.issue_valid, bus.empty); end
    endtask
`else
    task automatic test_random();
        logic [BS-1:0] remaining;
        int exp_idx;
        int cur;
        int nxt;
        do_reset();
        alloc_n(BS);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        bus.dep_ready = '1;
        exp_idx = int'(m_lfsr[IDX_W-1:0]);
        @(negedge clk);
        n_checks++; if (bus.issue_valid !== 1'b1 || int'(bus.issue_idx) != exp_idx) begin n_fail++; $display("FAIL rnd_first: got valid=%0b idx=%0d expected 1/%0d", bus.issue_valid, bus.issue_idx, exp_idx); end
        remaining = '1;
        cur = exp_idx;
        for (int cyc = 0; cyc < 300 && remaining != '0; cyc++) begin
            bus.issue_ready = 1'($urandom_range(0, 1));
            nxt = cur;
            if (bus.issue_ready) begin
                remaining[cur] = 1'b0;
                nxt = first_from(remaining, int'(m_lfsr[IDX_W-1:0]));
            end
            @(negedge clk);
            if (nxt < 0) begin
                n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_last: got valid=%0b expected 0", bus.issue_valid); end
            end else begin
                n_checks++; if (bus.issue_valid !== 1'b1 || int'(bus.issue_idx) != nxt) begin n_fail++; $display("FAIL rnd_pick[%0d]: got valid=%0b idx=%0d expected 1/%0d", cyc, bus.issue_valid, bus.issue_idx, nxt); end
                cur = nxt;
            end
        end
        bus.issue_ready = 1'b0;
        n_checks++; if (remaining !== '0) begin n_fail++; $display("FAIL rnd_drain_timeout: got remaining=%h expected 0", remaining); end
        n_checks++; if (bus.empty !== 1'b1 || bus.occupancy !== 5'd0) begin n_fail++; $display("FAIL rnd_empty: got empty=%0b occ=%0d expected 1/0", bus.empty, bus.occupancy); end
        bus.dep_ready = '0;
    endtask
`endif

    task automatic test_flush();
        int exp_idx;
        do_reset();
        bus.dep_ready   = '1;
        bus.issue_ready = 1'b1;
        bus.alloc_req   = 1'b1;
        repeat (6) @(negedge clk);
        bus.issue_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.occupancy === 5'd0) begin n_fail++; $display("FAIL flush_pre: got valid=%0b occ=%0d expected 1/nonzero", bus.issue_valid, bus.occupancy); end
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL flush_gnt: got %0b expected 0", bus.alloc_gnt); end
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.alloc_req = 1'b0;
        bus.dep_ready = '0;
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got valid=%0b occ=%0d empty=%0b expected 0/0/1", bus.issue_valid, bus.occupancy, bus.empty); end
        // The start point after flush: 0 for round-robin, the undisturbed LFSR otherwise.
        alloc_n(BS);
        bus.dep_ready = '1;
`ifdef ESM_SCHED_RR_EN
        exp_idx = 0;
`else
        exp_idx = int'(m_lfsr[IDX_W-1:0]);
`endif
        @(negedge clk);
        n_checks++; if (bus.issue_valid !== 1'b1 || int'(bus.issue_idx) != exp_idx) begin n_fail++; $display("FAIL flush_restart: got valid=%0b idx=%0d expected 1/%0d", bus.issue_valid, bus.issue_idx, exp_idx); end
        bus.dep_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_concurrent();
        test_stall();
`ifdef ESM_SCHED_RR_EN
        test_rr();
`else
        test_random();
`endif
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
